// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch and multi-cycle mul/div.
// Optional hazard performance counters are enabled with `define HAZ_PERF_CNT_EN.
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] IF_ID_rs,
    input  logic [4:0] IF_ID_rt,
    input  logic       id_uses_rt,
    input  logic [4:0] ID_EX_rt,
    input  logic       ID_EX_memRead,
    input  logic       branch_taken_ex,
    input  logic       md_start,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       flush_id,
    output logic       flush_ex,
    output logic       md_busy,
`ifdef HAZ_PERF_CNT_EN
    output logic       md_done,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`else
    output logic       md_done
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             md_done_q, md_done_nxt;

    logic load_use;
    logic md_accept;
    logic md_stall;
    logic stall_if_c, stall_id_c, stall_ex_c, flush_id_c, flush_ex_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            md_done_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            md_done_q <= md_done_nxt;
        end
    end

    always_comb begin
        load_use = ID_EX_memRead && (ID_EX_rt != 5'd0) &&
                   ((ID_EX_rt == IF_ID_rs) || (id_uses_rt && (ID_EX_rt == IF_ID_rt)));
        // A taken branch squashes the mul/div in EX, so it must not start.
        md_accept = md_start && !branch_taken_ex && (state != S_BUSY);
        md_stall  = (state == S_BUSY) || md_accept;

        state_nxt   = state;
        cnt_nxt     = cnt;
        md_done_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (md_accept) begin
                    state_nxt = S_BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (cnt <= CNT_ONE) begin
                    state_nxt   = S_DONE;
                    cnt_nxt     = '0;
                    md_done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_DONE: begin
                if (md_accept) begin
                    state_nxt = S_BUSY;
                    cnt_nxt   = CNT_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        stall_if_c = 1'b0;
        stall_id_c = 1'b0;
        stall_ex_c = 1'b0;
        flush_id_c = 1'b0;
        flush_ex_c = 1'b0;

        if (md_stall) begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            stall_ex_c = 1'b1;
        end else if (branch_taken_ex) begin
            flush_id_c = 1'b1;
            flush_ex_c = 1'b1;
        end else if (load_use) begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            flush_ex_c = 1'b1;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign stall_if = rst_n & stall_if_c;
    assign stall_id = rst_n & stall_id_c;
    assign stall_ex = rst_n & stall_ex_c;
    assign flush_id = rst_n & flush_id_c;
    assign flush_ex = rst_n & flush_ex_c;
    assign md_busy  = (state != S_IDLE);
    assign md_done  = md_done_q;

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_if) stall_cycles <= stall_cycles + 32'd1;
            if (flush_id) flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
`default_nettype none

module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] IF_ID_rs = '0, IF_ID_rt = '0, ID_EX_rt = '0;
    logic       id_uses_rt = 1'b0, ID_EX_memRead = 1'b0, branch_taken_ex = 1'b0, md_start = 1'b0;
    logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, md_busy, md_done;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
    int unsigned exp_stall_cnt = 0, exp_flush_cnt = 0;
`endif

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .id_uses_rt(id_uses_rt),
        .ID_EX_rt(ID_EX_rt), .ID_EX_memRead(ID_EX_memRead),
        .branch_taken_ex(branch_taken_ex), .md_start(md_start),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .md_busy(md_busy),
`ifdef HAZ_PERF_CNT_EN
        .md_done(md_done), .stall_cycles(stall_cycles), .flush_events(flush_events)
`else
        .md_done(md_done)
`endif
    );

    // exp = {stall_if, stall_id, stall_ex, flush_id, flush_ex, md_busy, md_done}
    task automatic drive(input string nm, input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ur, input logic [4:0] ert, input logic mr,
                         input logic br, input logic ms, input logic [6:0] exp);
        @(posedge clk);
        #1;
        rst_n = rst; IF_ID_rs = rs; IF_ID_rt = rt; id_uses_rt = ur;
        ID_EX_rt = ert; ID_EX_memRead = mr; branch_taken_ex = br; md_start = ms;
        exp_q.push_back(exp);
        name_q.push_back(nm);
`ifdef HAZ_PERF_CNT_EN
        if (!rst) begin
            exp_stall_cnt = 0;
            exp_flush_cnt = 0;
        end else begin
            if (exp[6]) exp_stall_cnt++;
            if (exp[3]) exp_flush_cnt++;
        end
`endif
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [6:0] e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {stall_if, stall_id, stall_ex, flush_id, flush_ex, md_busy, md_done};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", nm, a, e);
            end
        end
    end

    initial begin
        // Outputs must be low while reset is held, even with a live hazard.
        drive("reset_hold",  0, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 7'b0000000);
        drive("idle",        1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b0000000);
        drive("lu_rs",       1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 7'b1100100);
        drive("lu_clear",    1, 5'd5, 5'd0, 0, 5'd5, 0, 0, 0, 7'b0000000);
        drive("rt_gated",    1, 5'd3, 5'd7, 0, 5'd7, 1, 0, 0, 7'b0000000);
        drive("rt_used",     1, 5'd3, 5'd7, 1, 5'd7, 1, 0, 0, 7'b1100100);
        drive("r0_rs_rt",    1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 7'b0000000);
        drive("no_load",     1, 5'd5, 5'd5, 1, 5'd5, 0, 0, 0, 7'b0000000);
        drive("br_over_lu",  1, 5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 7'b0001100);
        // mul/div at T with a live hazard and branch during BUSY: stall wins, no flush
        drive("md_T",        1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 7'b1110000);
        drive("md_T1",       1, 5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 7'b1110010);
        drive("md_T2",       1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 7'b1110010);
        drive("md_T3",       1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b1110010);
        drive("md_T4_b2b",   1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 7'b1110011);
        drive("md2_T5",      1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b1110010);
        drive("md2_T6",      1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b1110010);
        drive("md2_T7",      1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b1110010);
        drive("md2_done",    1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b0000011);
        drive("md2_idle",    1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b0000000);
        drive("md_br_ill",   1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 7'b0001100);
        drive("md_br_idle",  1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b0000000);
        // load-use seen in the DONE cycle is serviced there
        drive("md3_T",       1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 7'b1110000);
        drive("md3_T1",      1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b1110010);
        drive("md3_T2",      1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b1110010);
        drive("md3_T3",      1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b1110010);
        drive("md3_done_lu", 1, 5'd9, 5'd0, 0, 5'd9, 1, 0, 0, 7'b1100111);
        drive("md3_idle",    1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b0000000);
        // reset asserted between edges in the middle of a mul/div
        drive("md4_T",       1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 7'b1110000);
        drive("md4_T1",      1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b1110010);
        drive("rst_mid",     0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b0000000);
        drive("rst_held",    0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b0000000);
        drive("rst_rel",     1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b0000000);
        drive("post_rst1",   1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b0000000);
        drive("post_rst2",   1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b0000000);
        drive("post_rst3",   1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b0000000);
`ifdef HAZ_PERF_CNT_EN
        drive("perf_lu",     1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 7'b1100100);
        drive("perf_br",     1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 7'b0001100);
        drive("perf_md",     1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 7'b1110000);
        drive("perf_md1",    1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b1110010);
        drive("perf_md2",    1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b1110010);
        drive("perf_md3",    1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b1110010);
        drive("perf_done",   1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 7'b0000011);
        @(posedge clk);
        #2;
        checks++;
        if (stall_cycles !== 32'(exp_stall_cnt)) begin
            errors++;
            $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, exp_stall_cnt);
        end
        checks++;
        if (flush_events !== 32'(exp_flush_cnt)) begin
            errors++;
            $display("FAIL flush_events: got %0d expected %0d", flush_events, exp_flush_cnt);
        end
`endif
        begin
            int waited;
            waited = 0;
            while (exp_q.size() > 0 && waited < 100) begin
                @(posedge clk);
                waited++;
            end
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
